alu_op_sequencer: RTL

//  Initiator for the ALU/dual-port-RAM datapath: accepts packed instructions over a valid/ready port,

---
 rtl/alu_op_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for the ALU/dual-port-RAM datapath: FIFO-buffered instructions, EXEC/WB issue, result return.
// Optional macro ALU_SEQ_COND_WB_EN gates writeback on a condition over the flags captured in EXEC.
module alu_op_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [31:0]                   instr_in,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    output logic [AW-1:0]                 Addr_A,
    output logic [AW-1:0]                 Addr_B,
    output logic [3:0]                    Opcode,
    output logic                          Cin,
    output logic [AW-1:0]                 Addr_Z,
    output logic                          WE_Z,
    input  logic [DW-1:0]                 Z_In,
    input  logic [2:0]                    Flags_In,
    output logic [DW-1:0]                 res_data,
    output logic [2:0]                    res_flags,
    output logic                          res_wrote,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   head;
    logic          push, pop;
    logic [CW-1:0] count_d;
    logic          ir_wb;
    logic [AW-1:0] ir_addr_z;
    logic          we_z_q;
    logic          we_dec;

    assign head    = fifo_mem[rd_ptr];
    assign push    = instr_valid & instr_ready;
    assign count_d = fifo_count + CW'(push) - CW'(pop);

    // Reset must kill a pending writeback in the very cycle it is asserted.
    assign WE_Z = we_z_q & ~RST;

`ifdef ALU_SEQ_COND_WB_EN
    logic [1:0] ir_cond;
    logic       cond_ok;

    // Flags_In during EXEC are exactly the values captured into res_flags.
    always_comb begin
        cond_ok = 1'b1;
        unique case (ir_cond)
            2'b00: cond_ok = 1'b1;
            2'b01: cond_ok = Flags_In[0];
            2'b10: cond_ok = Flags_In[2];
            2'b11: cond_ok = Flags_In[1];
            default: cond_ok = 1'b1;
        endcase
    end

    assign we_dec = ir_wb & cond_ok;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_cond <= 2'b00;
        end else if (pop) begin
            ir_cond <= head[31:30];
        end
    end
`else
    logic unused_cond;

    assign unused_cond = ^head[31:30];
    assign we_dec      = ir_wb;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fifo_count != CW'(0)) begin
                    pop     = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_RESP;
            S_RESP: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= instr_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            Addr_A      <= '0;
            Addr_B      <= '0;
            Opcode      <= '0;
            Cin         <= 1'b0;
            Addr_Z      <= '0;
            ir_wb       <= 1'b0;
            ir_addr_z   <= '0;
            we_z_q      <= 1'b0;
            res_data    <= '0;
            res_flags   <= '0;
            res_wrote   <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                Opcode    <= head[3:0];
                Cin       <= head[4];
                ir_wb     <= head[5];
                Addr_A    <= AW'(head[13:6]);
                Addr_B    <= AW'(head[21:14]);
                ir_addr_z <= AW'(head[29:22]);
            end
            // Operands stay on the bus through WB so the datapath writes the live result.
            if (state == S_EXEC) begin
                res_data  <= Z_In;
                res_flags <= Flags_In;
                res_wrote <= we_dec;
                we_z_q    <= we_dec;
                Addr_Z    <= ir_addr_z;
            end else begin
                we_z_q    <= 1'b0;
            end
            fifo_count  <= count_d;
            instr_ready <= (count_d != CW'(FIFO_DEPTH));
            busy        <= (state_d != S_IDLE) || (count_d != CW'(0));
            res_valid   <= (state_d == S_RESP);
        end
    end

endmodule
